// File: rtl/awmf_pkg.sv
// Shared definitions for the awmf0165 chain controller: frame width, chain mode
// encodings, controller state encoding and the captured-request record.
package awmf_pkg;

  localparam int FRAME_W = 240;

  localparam logic [1:0] CHAIN_SERIAL     = 2'b01;
  localparam logic [1:0] PARALLEL_TX      = 2'b10;
  localparam logic [1:0] SINGLE_SERIAL_TX = 2'b11;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_SETTLE    = 3'd4;
  localparam logic [2:0] ST_COMPLETE  = 3'd5;

  typedef enum logic {
    SRC_BEAM = 1'b0,
    SRC_CFG  = 1'b1
  } src_e;

  typedef struct packed {
    src_e               src;
    logic [1:0]         mode;
    logic [FRAME_W-1:0] data;
  } txn_t;

  // Mode 00 is the only encoding the chain cannot run.
  function automatic logic mode_valid(input logic [1:0] mode);
    return mode inside {CHAIN_SERIAL, PARALLEL_TX, SINGLE_SERIAL_TX};
  endfunction

endpackage

// File: rtl/awmf_rr_arb.sv
// Two-way arbiter: beam has priority, but after BURST_MAX consecutive beam grants
// with cfg waiting, cfg gets the next grant.
module awmf_rr_arb #(
  parameter int BURST_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic arb_en_i,
  input  logic beam_req_i,
  input  logic cfg_req_i,
  output logic gnt_beam_o,
  output logic gnt_cfg_o
);

  localparam int CW = $clog2(BURST_MAX + 1);

  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          burst_full;

  assign burst_full = (burst_cnt_q == CW'(BURST_MAX));

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    gnt_beam_o = 1'b0;
    gnt_cfg_o  = 1'b0;
    if (arb_en_i) begin
      if (beam_req_i && cfg_req_i) begin
        gnt_cfg_o  = burst_full;
        gnt_beam_o = !burst_full;
      end else begin
        gnt_beam_o = beam_req_i;
        gnt_cfg_o  = cfg_req_i;
      end
    end
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (!cfg_req_i || gnt_cfg_o) begin
      burst_cnt_d = '0;
    end else if (gnt_beam_o) begin
      burst_cnt_d = burst_cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/awmf0165_ctrl.sv
// Sequencer in front of one awmf0165_chain: arbitrates beam/cfg requests, runs one
// chain frame per transaction, returns the readback and flags timeouts.
module awmf0165_ctrl
  import awmf_pkg::*;
#(
  parameter int BEAM_BURST_MAX = 4,
  parameter int LAUNCH_MAX     = 16,
  parameter int FRAME_MAX      = 1023,
  parameter int RX_SETTLE      = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               beam_req_i,
  input  logic [1:0]         beam_mode_i,
  input  logic [FRAME_W-1:0] beam_data_i,
  output logic               beam_ack_o,
  input  logic               cfg_req_i,
  input  logic [1:0]         cfg_mode_i,
  input  logic [FRAME_W-1:0] cfg_data_i,
  output logic               cfg_ack_o,
  output logic               done_o,
  output logic               done_src_o,
  output logic [FRAME_W-1:0] rx_data_o,
  output logic               err_timeout_o,
  output logic               err_mode_o,
  output logic               chain_tx_en_o,
  output logic [1:0]         chain_tx_mode_o,
  output logic [FRAME_W-1:0] chain_tx_data_o,
  input  logic               chain_tx_busy_i,
  input  logic [FRAME_W-1:0] chain_rx_data_i
);

  // Last count value of each phase; tx_en is high for LAUNCH_MAX cycles in total
  // (one LAUNCH cycle plus LAUNCH_MAX-1 WAIT_BUSY cycles).
  localparam logic [9:0] LAUNCH_LAST = 10'(LAUNCH_MAX - 2);
  localparam logic [9:0] FRAME_LAST  = 10'(FRAME_MAX - 1);
  localparam logic [9:0] SETTLE_LAST = 10'(RX_SETTLE - 1);

  logic [2:0]         state_q, state_d;
  logic [9:0]         cnt_q, cnt_d;
  logic               busy_q;
  txn_t               txn_q, txn_d;
  logic               beam_ack_q, beam_ack_d;
  logic               cfg_ack_q, cfg_ack_d;
  logic               done_q, done_d;
  logic               done_src_q, done_src_d;
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic               err_to_q, err_to_d;
  logic               err_mode_q, err_mode_d;
  logic               en_q, en_d;

  logic               arb_en;
  logic               gnt_beam, gnt_cfg;
  logic [1:0]         gnt_mode;
  logic [FRAME_W-1:0] gnt_data;

  // Arbitration pauses during an ack cycle so a rejected (mode 00) requester
  // still holding its level request is not granted twice.
  assign arb_en = (state_q == ST_IDLE) && !beam_ack_q && !cfg_ack_q;

  awmf_rr_arb #(
    .BURST_MAX (BEAM_BURST_MAX)
  ) u_arb (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .arb_en_i   (arb_en),
    .beam_req_i (beam_req_i),
    .cfg_req_i  (cfg_req_i),
    .gnt_beam_o (gnt_beam),
    .gnt_cfg_o  (gnt_cfg)
  );

  assign gnt_mode = gnt_cfg ? cfg_mode_i : beam_mode_i;
  assign gnt_data = gnt_cfg ? cfg_data_i : beam_data_i;

  always_comb begin
    state_d    = state_q;
    txn_d      = txn_q;
    beam_ack_d = 1'b0;
    cfg_ack_d  = 1'b0;
    done_d     = 1'b0;
    done_src_d = done_src_q;
    rx_d       = rx_q;
    err_to_d   = err_to_q;
    err_mode_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_beam || gnt_cfg) begin
          beam_ack_d = gnt_beam;
          cfg_ack_d  = gnt_cfg;
          err_to_d   = 1'b0;
          if (mode_valid(gnt_mode)) begin
            txn_d.src  = gnt_cfg ? SRC_CFG : SRC_BEAM;
            txn_d.mode = gnt_mode;
            txn_d.data = gnt_data;
            state_d    = ST_LAUNCH;
          end else begin
            err_mode_d = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (busy_q) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == LAUNCH_LAST) begin
          err_to_d = 1'b1;
          state_d  = ST_COMPLETE;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy_q) begin
          state_d = ST_SETTLE;
        end else if (cnt_q == FRAME_LAST) begin
          err_to_d = 1'b1;
          state_d  = ST_COMPLETE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          rx_d    = chain_rx_data_i;
          state_d = ST_COMPLETE;
        end
      end
      ST_COMPLETE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // One phase counter serves all states; it restarts on every state change.
    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 10'd1;
    end

    if ((state_d == ST_COMPLETE) && (state_q != ST_COMPLETE)) begin
      done_d     = 1'b1;
      done_src_d = txn_q.src;
    end

    en_d = (state_d == ST_LAUNCH) || (state_d == ST_WAIT_BUSY);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      txn_q      <= '0;
      beam_ack_q <= 1'b0;
      cfg_ack_q  <= 1'b0;
      done_q     <= 1'b0;
      done_src_q <= 1'b0;
      rx_q       <= '0;
      err_to_q   <= 1'b0;
      err_mode_q <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= chain_tx_busy_i;
      txn_q      <= txn_d;
      beam_ack_q <= beam_ack_d;
      cfg_ack_q  <= cfg_ack_d;
      done_q     <= done_d;
      done_src_q <= done_src_d;
      rx_q       <= rx_d;
      err_to_q   <= err_to_d;
      err_mode_q <= err_mode_d;
      en_q       <= en_d;
    end
  end

  assign beam_ack_o      = beam_ack_q;
  assign cfg_ack_o       = cfg_ack_q;
  assign done_o          = done_q;
  assign done_src_o      = done_src_q;
  assign rx_data_o       = rx_q;
  assign err_timeout_o   = err_to_q;
  assign err_mode_o      = err_mode_q;
  assign chain_tx_en_o   = en_q;
  assign chain_tx_mode_o = txn_q.mode;
  assign chain_tx_data_o = txn_q.data;

endmodule
